// File: rtl/reg_bank_mp.sv
// Multi-port general-purpose register bank with write-through bypass,
// a per-register pending scoreboard and a registered debug read port.
// Latency: reads and busy flags are combinational (zero cycles). Writes,
//          pending updates, Dbg_Data and Conflict take effect at the next
//          rising edge. Backpressure: none; every port is accepted every cycle.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   We_A/Wa_A/Wd_A      write port A (ALU writeback)
//   We_B/Wa_B/Wd_B      write port B (memory writeback), wins on address clash
//   Rd_Addr/Rd_Data     NUM_RD packed combinational read slots
//   Rd_Busy             per-slot "addressed register has an outstanding producer"
//   Issue_Valid/Addr    marks a destination register as pending
//   Dbg_Addr/Dbg_Data   registered debug read of stored state (no bypass)
//   Conflict            one-cycle pulse after both ports wrote the same register

module reg_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,

    input  logic                     We_A,
    input  logic [ADDR_W-1:0]        Wa_A,
    input  logic [DATA_W-1:0]        Wd_A,

    input  logic                     We_B,
    input  logic [ADDR_W-1:0]        Wa_B,
    input  logic [DATA_W-1:0]        Wd_B,

    input  logic [NUM_RD*ADDR_W-1:0] Rd_Addr,
    output logic [NUM_RD*DATA_W-1:0] Rd_Data,
    output logic [NUM_RD-1:0]        Rd_Busy,

    input  logic                     Issue_Valid,
    input  logic [ADDR_W-1:0]        Issue_Addr,

    input  logic [ADDR_W-1:0]        Dbg_Addr,
    output logic [DATA_W-1:0]        Dbg_Data,

    output logic                     Conflict
);

    localparam int NREGS = 1 << ADDR_W;

    // Storage and scoreboard state
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] dbg_d;
    logic              conflict_q;
    logic              conflict_d;

    // Qualified write / issue enables: with a hardwired zero register,
    // anything aimed at address 0 is simply dropped here so that the
    // storage, scoreboard and conflict logic never see it.
    logic wr_a_en;
    logic wr_b_en;
    logic issue_en;

    always_comb begin
        wr_a_en  = We_A;
        wr_b_en  = We_B;
        issue_en = Issue_Valid;
        if (ZERO_REG != 0) begin
            if (Wa_A == '0)       wr_a_en  = 1'b0;
            if (Wa_B == '0)       wr_b_en  = 1'b0;
            if (Issue_Addr == '0) issue_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // Port B is written after port A so that it wins on an address clash.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (wr_a_en) mem_q[Wa_A] <= Wd_A;
            if (wr_b_en) mem_q[Wa_B] <= Wd_B;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------
    // Completing writes clear first, then a new issue sets: when a register
    // is both written and re-issued in one cycle the new producer is still
    // outstanding, so the bit must end up set.
    always_comb begin
        pend_d = pend_q;
        if (wr_a_en)  pend_d[Wa_A]       = 1'b0;
        if (wr_b_en)  pend_d[Wa_B]       = 1'b0;
        if (issue_en) pend_d[Issue_Addr] = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Conflict pulse and debug read
    // ------------------------------------------------------------------
    always_comb begin
        conflict_d = wr_a_en && wr_b_en && (Wa_A == Wa_B);
        dbg_d      = mem_q[Dbg_Addr];
        if ((ZERO_REG != 0) && (Dbg_Addr == '0)) begin
            dbg_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            conflict_q <= 1'b0;
            dbg_q      <= '0;
        end else begin
            conflict_q <= conflict_d;
            dbg_q      <= dbg_d;
        end
    end

    assign Conflict = conflict_q;
    assign Dbg_Data = dbg_q;

    // ------------------------------------------------------------------
    // Combinational read slots
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_dat;
        logic              rd_busy;
        logic              is_zero;
        logic              hit_a;
        logic              hit_b;

        assign rd_addr = Rd_Addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            is_zero = (ZERO_REG != 0) && (rd_addr == '0);
            // Hits use the qualified enables; address 0 is already covered
            // by is_zero when the zero register is hardwired.
            hit_a   = (BYPASS != 0) && wr_a_en && (Wa_A == rd_addr);
            hit_b   = (BYPASS != 0) && wr_b_en && (Wa_B == rd_addr);

            if (is_zero) begin
                rd_dat = '0;
            end else if (hit_b) begin
                rd_dat = Wd_B;
            end else if (hit_a) begin
                rd_dat = Wd_A;
            end else begin
                rd_dat = mem_q[rd_addr];
            end

            // A forwarded result is already the final value, so the
            // consumer need not stall even though the bit is still set.
            rd_busy = pend_q[rd_addr] && !is_zero && !hit_a && !hit_b;
        end

        assign Rd_Data[i*DATA_W +: DATA_W] = rd_dat;
        assign Rd_Busy[i]                  = rd_busy;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
module tb_reg_bank_mp;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          We_A;
    logic [AW-1:0] Wa_A;
    logic [DW-1:0] Wd_A;
    logic          We_B;
    logic [AW-1:0] Wa_B;
    logic [DW-1:0] Wd_B;
    logic [NR*AW-1:0] Rd_Addr;
    logic          Issue_Valid;
    logic [AW-1:0] Issue_Addr;
    logic [AW-1:0] Dbg_Addr;

    logic [NR*DW-1:0] byp_rd_data, nob_rd_data;
    logic [NR-1:0]    byp_rd_busy, nob_rd_busy;
    logic [DW-1:0]    byp_dbg, nob_dbg;
    logic             byp_conf, nob_conf;

    always #5 Clock = ~Clock;

    reg_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .Clock(Clock), .Reset(Reset),
        .We_A(We_A), .Wa_A(Wa_A), .Wd_A(Wd_A),
        .We_B(We_B), .Wa_B(Wa_B), .Wd_B(Wd_B),
        .Rd_Addr(Rd_Addr), .Rd_Data(byp_rd_data), .Rd_Busy(byp_rd_busy),
        .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
        .Dbg_Addr(Dbg_Addr), .Dbg_Data(byp_dbg), .Conflict(byp_conf)
    );

    reg_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .Clock(Clock), .Reset(Reset),
        .We_A(We_A), .Wa_A(Wa_A), .Wd_A(Wd_A),
        .We_B(We_B), .Wa_B(Wa_B), .Wd_B(Wd_B),
        .Rd_Addr(Rd_Addr), .Rd_Data(nob_rd_data), .Rd_Busy(nob_rd_busy),
        .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
        .Dbg_Addr(Dbg_Addr), .Dbg_Data(nob_dbg), .Conflict(nob_conf)
    );

    // Observation points: 0..2 data (bypass DUT), 3..5 data (no-bypass DUT),
    // 6..8 busy (bypass), 9..11 busy (no-bypass), 12 dbg byp, 13 conflict byp,
    // 14 dbg nob, 15 conflict nob.
    localparam int D_B = 0, D_N = 3, B_B = 6, B_N = 9;
    localparam int DBG_B = 12, CNF_B = 13, DBG_N = 14, CNF_N = 15;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (sel < 3)        v = byp_rd_data[sel*DW +: DW];
        else if (sel < 6)   v = nob_rd_data[(sel-3)*DW +: DW];
        else if (sel < 9)   v = {31'd0, byp_rd_busy[sel-6]};
        else if (sel < 12)  v = {31'd0, nob_rd_busy[sel-9]};
        else if (sel == 12) v = byp_dbg;
        else if (sel == 13) v = {31'd0, byp_conf};
        else if (sel == 14) v = nob_dbg;
        else if (sel == 15) v = {31'd0, nob_conf};
        return v;
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Sample away from the clock edge and drain every queued expectation.
    task automatic check_now();
        exp_t e;
        logic [31:0] got;
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.sel);
            vectors++;
            assert (got === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_rd(input int slot, input logic [AW-1:0] a);
        Rd_Addr[slot*AW +: AW] = a;
    endtask

    task automatic idle_inputs();
        We_A = 1'b0; Wa_A = '0; Wd_A = '0;
        We_B = 1'b0; Wa_B = '0; Wd_B = '0;
        Issue_Valid = 1'b0; Issue_Addr = '0;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        Dbg_Addr = '0;
        Rd_Addr  = '0;
        set_rd(0, 6'd5); set_rd(1, 6'd1); set_rd(2, 6'd2);
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        for (int k = 0; k < NR; k++) begin
            expect_val("rst_data_b", D_B + k, 32'h0);
            expect_val("rst_data_n", D_N + k, 32'h0);
            expect_val("rst_busy_b", B_B + k, 32'h0);
        end
        expect_val("rst_dbg", DBG_B, 32'h0);
        expect_val("rst_conf", CNF_B, 32'h0);
        check_now();

        // Write A to reg 5: forwarded on bypass DUT only, stored for both
        We_A = 1'b1; Wa_A = 6'd5; Wd_A = 32'h1234;
        expect_val("wrA5_fwd_b", D_B + 0, 32'h1234);
        expect_val("wrA5_fwd_n", D_N + 0, 32'h0);
        check_now();
        tick();
        idle_inputs();
        Dbg_Addr = 6'd5;
        expect_val("rd5_b", D_B + 0, 32'h1234);
        expect_val("rd5_n", D_N + 0, 32'h1234);
        check_now();
        tick();
        expect_val("dbg5_b", DBG_B, 32'h1234);
        expect_val("dbg5_n", DBG_N, 32'h1234);
        expect_val("rd1_zero", D_B + 1, 32'h0);
        expect_val("rd2_zero", D_N + 2, 32'h0);
        check_now();

        // Same-cycle bypass on slot 1
        set_rd(1, 6'd7);
        We_A = 1'b1; Wa_A = 6'd7; Wd_A = 32'hAAAA;
        expect_val("byp7_b", D_B + 1, 32'hAAAA);
        expect_val("byp7_n_old", D_N + 1, 32'h0);
        check_now();
        tick();
        idle_inputs();
        expect_val("rd7_b", D_B + 1, 32'hAAAA);
        expect_val("rd7_n_next", D_N + 1, 32'hAAAA);
        check_now();

        // Write collision on reg 9: B wins, Conflict pulses once
        set_rd(2, 6'd9);
        We_A = 1'b1; Wa_A = 6'd9; Wd_A = 32'h1;
        We_B = 1'b1; Wa_B = 6'd9; Wd_B = 32'h2;
        expect_val("coll_fwd_b", D_B + 2, 32'h2);
        expect_val("coll_conf_pre", CNF_B, 32'h0);
        check_now();
        tick();
        idle_inputs();
        expect_val("coll_rd9_b", D_B + 2, 32'h2);
        expect_val("coll_rd9_n", D_N + 2, 32'h2);
        expect_val("coll_conf_b", CNF_B, 32'h1);
        expect_val("coll_conf_n", CNF_N, 32'h1);
        check_now();
        tick();
        expect_val("coll_conf_drop_b", CNF_B, 32'h0);
        expect_val("coll_conf_drop_n", CNF_N, 32'h0);
        check_now();

        // Both ports writing reg 0: dropped, no conflict
        set_rd(0, 6'd0);
        We_A = 1'b1; Wa_A = 6'd0; Wd_A = 32'h5;
        We_B = 1'b1; Wa_B = 6'd0; Wd_B = 32'h6;
        expect_val("z_coll_fwd_b", D_B + 0, 32'h0);
        check_now();
        tick();
        idle_inputs();
        expect_val("z_coll_conf_b", CNF_B, 32'h0);
        expect_val("z_coll_rd0_n", D_N + 0, 32'h0);
        check_now();

        // Scoreboard: issue reg 12
        set_rd(0, 6'd12);
        Issue_Valid = 1'b1; Issue_Addr = 6'd12;
        expect_val("iss12_busy_pre", B_B + 0, 32'h0);
        check_now();
        tick();
        idle_inputs();
        expect_val("iss12_busy_b", B_B + 0, 32'h1);
        expect_val("iss12_busy_n", B_N + 0, 32'h1);
        check_now();
        // Writeback to 12: forwarded so not busy on bypass DUT
        We_A = 1'b1; Wa_A = 6'd12; Wd_A = 32'h55;
        expect_val("wb12_busy_b", B_B + 0, 32'h0);
        expect_val("wb12_busy_n", B_N + 0, 32'h1);
        expect_val("wb12_data_b", D_B + 0, 32'h55);
        expect_val("wb12_data_n", D_N + 0, 32'h0);
        check_now();
        tick();
        idle_inputs();
        expect_val("clr12_busy_b", B_B + 0, 32'h0);
        expect_val("clr12_busy_n", B_N + 0, 32'h0);
        expect_val("clr12_data_n", D_N + 0, 32'h55);
        check_now();
        // Issue and write 12 together: new producer keeps it pending
        Issue_Valid = 1'b1; Issue_Addr = 6'd12;
        We_A = 1'b1; Wa_A = 6'd12; Wd_A = 32'h66;
        tick();
        idle_inputs();
        expect_val("reiss12_busy_b", B_B + 0, 32'h1);
        expect_val("reiss12_busy_n", B_N + 0, 32'h1);
        expect_val("reiss12_data_b", D_B + 0, 32'h66);
        check_now();

        // Zero register: write and issue are ignored
        set_rd(0, 6'd0); set_rd(1, 6'd0); set_rd(2, 6'd0);
        Dbg_Addr = 6'd0;
        We_A = 1'b1; Wa_A = 6'd0; Wd_A = 32'hFFFF;
        Issue_Valid = 1'b1; Issue_Addr = 6'd0;
        for (int k = 0; k < NR; k++) begin
            expect_val("z_fwd_b", D_B + k, 32'h0);
        end
        check_now();
        tick();
        idle_inputs();
        for (int k = 0; k < NR; k++) begin
            expect_val("z_data_b", D_B + k, 32'h0);
            expect_val("z_data_n", D_N + k, 32'h0);
            expect_val("z_busy_b", B_B + k, 32'h0);
            expect_val("z_busy_n", B_N + k, 32'h0);
        end
        check_now();
        tick();
        expect_val("z_dbg_b", DBG_B, 32'h0);
        expect_val("z_dbg_n", DBG_N, 32'h0);
        check_now();

        // Reset mid-operation
        We_A = 1'b1; Wa_A = 6'd3; Wd_A = 32'h33;
        We_B = 1'b1; Wa_B = 6'd4; Wd_B = 32'h44;
        tick();
        idle_inputs();
        Issue_Valid = 1'b1; Issue_Addr = 6'd4;
        Dbg_Addr = 6'd3;
        set_rd(0, 6'd4); set_rd(1, 6'd3); set_rd(2, 6'd12);
        tick();
        idle_inputs();
        expect_val("pre_rst_dbg3", DBG_B, 32'h33);
        expect_val("pre_rst_busy4", B_B + 0, 32'h1);
        expect_val("pre_rst_rd4_n", D_N + 0, 32'h44);
        expect_val("pre_rst_rd3", D_B + 1, 32'h33);
        expect_val("pre_rst_busy12", B_N + 2, 32'h1);
        check_now();
        Reset = 1'b1;
        We_A = 1'b1; Wa_A = 6'd3; Wd_A = 32'h99;
        We_B = 1'b1; Wa_B = 6'd3; Wd_B = 32'h77;
        Issue_Valid = 1'b1; Issue_Addr = 6'd4;
        tick();
        Reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < NR; k++) begin
            expect_val("post_rst_data_b", D_B + k, 32'h0);
            expect_val("post_rst_data_n", D_N + k, 32'h0);
            expect_val("post_rst_busy_b", B_B + k, 32'h0);
            expect_val("post_rst_busy_n", B_N + k, 32'h0);
        end
        expect_val("post_rst_dbg_b", DBG_B, 32'h0);
        expect_val("post_rst_dbg_n", DBG_N, 32'h0);
        expect_val("post_rst_conf_b", CNF_B, 32'h0);
        expect_val("post_rst_conf_n", CNF_N, 32'h0);
        check_now();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised multi-port general-purpose register bank; next generation of the processor's 64x32 register bank.
- Single clock domain, replacing the slow/fast clock write-capture scheme.
- Adds:
  - configurable width, depth and read-port count
  - two write ports with defined priority
  - write-through bypass
  - per-register pending scoreboard for hazard detection
  - registered debug read port, replacing the per-register debug buses
- Sits between decode (reads, issue marking) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 6, address width; NREGS = 2**ADDR_W registers.
- NUM_RD, 3, number of combinational read ports (1..8).
- ZERO_REG, 1, if 1, register 0 is hardwired to zero and never pending.
- BYPASS, 1, if 1, same-cycle write data is forwarded to read ports.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  Reset, synchronous, active-high.
- We_A  in  1  write enable, port A (ALU writeback).
- Wa_A  in  ADDR_W  write address, port A.
- Wd_A  in  DATA_W  write data, port A.
- We_B  in  1  write enable, port B (memory writeback).
- Wa_B  in  ADDR_W  write address, port B.
- Wd_B  in  DATA_W  write data, port B.
- Rd_Addr  in  NUM_RD*ADDR_W  packed read addresses; slot i = [i*ADDR_W +: ADDR_W].
- Rd_Data  out  NUM_RD*DATA_W  packed read data; slot i = [i*DATA_W +: DATA_W].
- Rd_Busy  out  NUM_RD  per-slot flag: addressed register has an outstanding producer.
- Issue_Valid  in  1  marks register Issue_Addr as pending.
- Issue_Addr  in  ADDR_W  destination register of the issued instruction.
- Dbg_Addr  in  ADDR_W  debug read address.
- Dbg_Data  out  DATA_W  registered debug read data.
- Conflict  out  1  registered pulse: both ports wrote the same address last cycle.

Behaviour:
- Reset (sampled at rising edge):
  - all NREGS registers = 0; all pending bits = 0; Dbg_Data = 0; Conflict = 0.
  - Reset dominates any write or issue in the same cycle.
  - Asserting Reset mid-sequence discards all pending state.
- Writes (rising edge):
  - When We_X=1, mem[Wa_X] <= Wd_X.
  - Both enabled, different addresses: both writes commit.
  - Both enabled, same address: port B wins; Conflict=1 for exactly the next cycle, otherwise 0.
  - ZERO_REG=1: writes to address 0 are dropped and do not raise Conflict.
- Reads (combinational, zero latency), per slot i with address a:
  - ZERO_REG=1 and a=0: data = 0.
  - Else if BYPASS=1 and We_B and Wa_B==a: Wd_B.
  - Else if BYPASS=1 and We_A and Wa_A==a: Wd_A.
  - Else mem[a].
  - BYPASS=0: stored value only; new data is visible the cycle after the write.
- Scoreboard (one pending bit per register, updated at rising edge):
  - Set: Issue_Valid=1 sets pending[Issue_Addr].
  - Clear: a write on A or B to an address clears that pending bit.
  - Issue and write to the same address in the same cycle: the bit stays set (new producer overrides the completing one).
  - ZERO_REG=1: issue to address 0 is ignored.
- Rd_Busy[i]:
  - = pending[a], except forced 0 when BYPASS=1 and a write to a hits this cycle (data already forwarded).
  - Always 0 for address 0 when ZERO_REG=1.
- Debug port:
  - Dbg_Data <= mem[Dbg_Addr] every cycle; one-cycle latency.
  - Reads stored state, no bypass.
  - Reads 0 for address 0 when ZERO_REG=1.
- No illegal addresses exist (full 2**ADDR_W decode).

Test Plan:
- Reset, then write A: Wa_A=5, Wd_A=0x1234 at cycle 1; read slot0 addr 5 at cycle 2 -> 0x1234. Dbg_Addr=5 -> Dbg_Data=0x1234 one cycle after sampling. Other slots/regs read 0.
- Same-cycle bypass (BYPASS=1): We_A, Wa_A=7, Wd_A=0xAAAA while slot1 reads 7 -> Rd_Data slot1 = 0xAAAA in the same cycle. Repeat with BYPASS=0 -> old value 0 that cycle, 0xAAAA next cycle.
- Write collision: We_A/We_B both to reg 9, Wd_A=1, Wd_B=2 -> reg 9 = 2; Conflict=1 for one cycle, then 0. Both writing reg 0 -> reg 0 stays 0, Conflict=0.
- Scoreboard: issue reg 12 -> next cycle Rd_Busy=1 on a slot reading 12. Write A to 12 with BYPASS=1 -> busy 0 that cycle, pending cleared after the edge. Issue 12 and write 12 in the same cycle -> busy remains 1 afterwards.
- Zero register: write 0xFFFF to reg 0 and issue reg 0 -> all reads of 0 return 0, Rd_Busy=0.
- Reset mid-operation: regs 3 and 4 written, reg 4 pending, Reset asserted together with a write to reg 3 -> after the edge all reads 0, no busy, Dbg_Data=0, Conflict=0.
